// File: rtl/tile_cfg_pkg.sv
// Shared decode definitions for the tile config bus.
// Field positions, special register indices and the decoded command.
package tile_cfg_pkg;

    localparam int TILE_LSB = 0;
    localparam int TILE_W   = 16;
    localparam int FEAT_LSB = 16;
    localparam int FEAT_W   = 8;
    localparam int REG_LSB  = 24;
    localparam int REG_W    = 8;

    localparam logic [REG_W-1:0]  COMMIT_REG   = 8'hFF;
    localparam logic [REG_W-1:0]  CLR_ERR_REG  = 8'hFE;
    localparam logic [TILE_W-1:0] BROADCAST_ID = 16'hFFFF;

    typedef struct packed {
        logic             hit;
        logic             we;
        logic [REG_W-1:0] idx;
    } cfg_cmd_t;

endpackage

// File: rtl/tile_cfg_decode.sv
// Combinational address decode for one tile feature.
// Broadcast tile ID only matches writes; broadcast reads are not hits.
module tile_cfg_decode
    import tile_cfg_pkg::*;
#(
    parameter logic [FEAT_W-1:0] FEATURE_ID = 8'h00
) (
    input  logic              en_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [TILE_W-1:0] tile_id_i,
    output cfg_cmd_t          cmd_o
);

    logic [TILE_W-1:0] tile;
    logic [FEAT_W-1:0] feat;
    logic              tile_match;

    assign tile = addr_i[TILE_LSB +: TILE_W];
    assign feat = addr_i[FEAT_LSB +: FEAT_W];

    // Own tile always matches; broadcast matches writes only.
    always_comb begin
        tile_match = (tile == tile_id_i) |
                     (we_i & (tile == BROADCAST_ID));
        cmd_o.hit  = en_i & tile_match & (feat == FEATURE_ID);
        cmd_o.we   = we_i;
        cmd_o.idx  = addr_i[REG_LSB +: REG_W];
    end

endmodule

// File: rtl/tile_config_receiver.sv
// Tile-side config receiver: shadow regs, atomic commit to active config,
// readback of the active config and a sticky decode error flag.
module tile_config_receiver
    import tile_cfg_pkg::*;
#(
    parameter logic [7:0] FEATURE_ID = 8'h00,
    parameter int         NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           tile_id,
    input  logic                  config_en,
    input  logic                  config_we,
    input  logic [31:0]           config_addr,
    input  logic [31:0]           config_data,
    output logic [31:0]           read_data,
    output logic                  read_valid,
    output logic [NUM_REGS*32-1:0] cfg_active,
    output logic                  cfg_committed,
    output logic                  cfg_all_written,
    output logic                  cfg_err
);

    cfg_cmd_t            cmd;
    logic [31:0]         shadow_q [NUM_REGS];
    logic [31:0]         active_q [NUM_REGS];
    logic [NUM_REGS-1:0] written_q;
    logic [31:0]         read_data_q;
    logic                read_valid_q;
    logic                committed_q;
    logic                err_q;
    logic [31:0]         rd_sel;
    logic                reg_ok;

    tile_cfg_decode #(
        .FEATURE_ID (FEATURE_ID)
    ) u_decode (
        .en_i      (config_en),
        .we_i      (config_we),
        .addr_i    (config_addr),
        .tile_id_i (tile_id),
        .cmd_o     (cmd)
    );

    // Range-check the register index and select its active value.
    always_comb begin
        rd_sel = '0;
        reg_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd.idx == 8'(i)) begin
                rd_sel = active_q[i];
                reg_ok = 1'b1;
            end
        end
    end

    assign cfg_all_written = &written_q;

    // Command execution: shadow writes, commit, readback and error tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            written_q    <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            committed_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            committed_q  <= 1'b0;
            if (cmd.hit && cmd.we) begin
                if (reg_ok) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (cmd.idx == 8'(i)) begin
                            shadow_q[i]  <= config_data;
                            written_q[i] <= 1'b1;
                        end
                    end
                end else if (cmd.idx == COMMIT_REG) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        active_q[i] <= shadow_q[i];
                    end
                    written_q   <= '0;
                    committed_q <= 1'b1;
                end else if (cmd.idx == CLR_ERR_REG) begin
                    err_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (cmd.hit) begin
                read_valid_q <= 1'b1;
                if (reg_ok) begin
                    read_data_q <= rd_sel;
                end else if (cmd.idx == COMMIT_REG) begin
                    read_data_q <= {31'b0, cfg_all_written};
                end else begin
                    read_data_q <= '0;
                    err_q       <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_active
        assign cfg_active[32*g +: 32] = active_q[g];
    end

    assign read_data     = read_data_q;
    assign read_valid    = read_valid_q;
    assign cfg_committed = committed_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_tile_config_receiver.sv
// Bench for tile_config_receiver: directed steps plus random commands
// checked against an array-based model of the config register file.
module tb_tile_config_receiver;

    localparam int          NR   = 8;
    localparam logic [7:0]  FEAT = 8'h00;
    localparam logic [15:0] TID  = 16'h0042;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [15:0]       tile_id = TID;
    logic              config_en = 1'b0;
    logic              config_we = 1'b0;
    logic [31:0]       config_addr = '0;
    logic [31:0]       config_data = '0;
    logic [31:0]       read_data;
    logic              read_valid;
    logic [NR*32-1:0]  cfg_active;
    logic              cfg_committed;
    logic              cfg_all_written;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_sh  [NR];
    logic [31:0] m_act [NR];
    bit          m_wr  [NR];
    bit          m_err;
    bit          m_rv;
    bit          m_cm;
    logic [31:0] m_rd;

    tile_config_receiver #(
        .FEATURE_ID (FEAT),
        .NUM_REGS   (NR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tile_id         (tile_id),
        .config_en       (config_en),
        .config_we       (config_we),
        .config_addr     (config_addr),
        .config_data     (config_data),
        .read_data       (read_data),
        .read_valid      (read_valid),
        .cfg_active      (cfg_active),
        .cfg_committed   (cfg_committed),
        .cfg_all_written (cfg_all_written),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_all();
        bit a = 1'b1;
        for (int i = 0; i < NR; i++) a &= m_wr[i];
        return a;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
            m_wr[i] = 1'b0;
        end
        m_err = 0;
        m_rv = 0;
        m_cm = 0;
        m_rd = '0;
    endtask

    task automatic m_step(input bit en, input bit we,
                          input logic [31:0] addr,
                          input logic [31:0] data);
        int r;
        bit hit;
        r = int'(addr[31:24]);
        hit = en && addr[23:16] == FEAT &&
              (addr[15:0] == TID || (we && addr[15:0] == 16'hFFFF));
        m_rv = 0;
        m_cm = 0;
        if (!hit) return;
        if (we) begin
            if (r < NR) begin
                m_sh[r] = data;
                m_wr[r] = 1;
            end else if (r == 255) begin
                for (int i = 0; i < NR; i++) begin
                    m_act[i] = m_sh[i];
                    m_wr[i] = 0;
                end
                m_cm = 1;
            end else if (r == 254) begin
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_rv = 1;
            if (r < NR) m_rd = m_act[r];
            else if (r == 255) m_rd = {31'b0, m_all()};
            else begin
                m_rd = '0;
                m_err = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rv"}, 32'(read_valid), 32'(m_rv));
        chk({tag, ".rd"}, read_data, m_rd);
        chk({tag, ".cm"}, 32'(cfg_committed), 32'(m_cm));
        chk({tag, ".err"}, 32'(cfg_err), 32'(m_err));
        chk({tag, ".aw"}, 32'(cfg_all_written), 32'(m_all()));
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s.act%0d", tag, i), cfg_active[32*i +: 32], m_act[i]);
    endtask

    task automatic cmd(input string tag, input bit en, input bit we,
                       input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        config_en = en;
        config_we = we;
        config_addr = addr;
        config_data = data;
        @(posedge clk);
        #1;
        m_step(en, we, addr, data);
        chk_all(tag);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [15:0] t;
        logic [7:0]  f;
        logic [7:0]  r;
        case ($urandom_range(0, 5))
            0: t = 16'hFFFF;
            1: t = 16'h0043;
            default: t = TID;
        endcase
        f = ($urandom_range(0, 9) == 0) ? 8'h01 : FEAT;
        case ($urandom_range(0, 9))
            0: r = 8'hFF;
            1: r = 8'hFE;
            2: r = 8'(NR + $urandom_range(0, 200));
            default: r = 8'($urandom_range(0, NR - 1));
        endcase
        return {r, f, t};
    endfunction

    initial begin
        m_reset();
        // 1: reset held for 8 cycles
        repeat (8) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // 2: write reg 0, read before commit, then commit
        cmd("s2_wr", 1, 1, 32'h0000_0042, 32'hDEADBEEF);
        cmd("s2_rd", 1, 0, 32'h0000_0042, 32'h0);
        chk("s2_rd_zero", read_data, 32'h0);
        cmd("s2_cm", 1, 1, 32'hFF00_0042, 32'h1234_5678);
        chk("s2_act0", cfg_active[31:0], 32'hDEADBEEF);
        cmd("s2_idle", 0, 0, 32'h0, 32'h0);
        chk("s2_cm_pulse", 32'(cfg_committed), 32'h0);

        // 3: broadcast writes to every reg, broadcast read, commit
        for (int i = 0; i < NR; i++)
            cmd("s3_bwr", 1, 1, {8'(i), FEAT, 16'hFFFF}, $urandom);
        chk("s3_allw", 32'(cfg_all_written), 32'h1);
        cmd("s3_brd", 1, 0, {8'h00, FEAT, 16'hFFFF}, 32'h0);
        cmd("s3_rdall", 1, 0, {8'hFF, FEAT, TID}, 32'h0);
        cmd("s3_cm", 1, 1, {8'hFF, FEAT, TID}, 32'h0);
        chk("s3_allw0", 32'(cfg_all_written), 32'h0);

        // 4: mismatched tile/feature, bad reg, clear error
        cmd("s4_tile", 1, 1, 32'h0000_0043, 32'hAAAA_5555);
        cmd("s4_feat", 1, 1, 32'h0001_0042, 32'hAAAA_5555);
        cmd("s4_cm", 1, 1, 32'hFF00_0042, 32'h0);
        cmd("s4_bad", 1, 0, 32'h2000_0042, 32'h0);
        chk("s4_err1", 32'(cfg_err), 32'h1);
        cmd("s4_clr", 1, 1, 32'hFE00_0042, 32'h0);
        chk("s4_err0", 32'(cfg_err), 32'h0);

        // 5: back-to-back burst of 20 writes then commit
        for (int i = 0; i < 20; i++)
            cmd("s5_burst", 1, 1, {8'($urandom_range(0, NR - 1)), FEAT, TID},
                $urandom);
        cmd("s5_cm", 1, 1, {8'hFF, FEAT, TID}, 32'h0);

        // random command mix
        for (int i = 0; i < 300; i++)
            cmd("rnd", 1'($urandom_range(0, 7) != 0), 1'($urandom),
                rand_addr(), $urandom);

        // reset in the middle of a 4-write burst
        cmd("s5r_w0", 1, 1, {8'h01, FEAT, TID}, 32'h1111_1111);
        cmd("s5r_w1", 1, 1, {8'h02, FEAT, TID}, 32'h2222_2222);
        @(negedge clk);
        config_addr = {8'h03, FEAT, TID};
        config_data = 32'h3333_3333;
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        chk_all("s5r_async");
        @(negedge clk);
        config_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cmd("s5r_cm", 1, 1, {8'hFF, FEAT, TID}, 32'h0);
        for (int i = 0; i < NR; i++)
            cmd("s5r_rd", 1, 0, {8'(i), FEAT, TID}, 32'h0);
        cmd("s5r_idle", 0, 0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
